if_stage: RTL and testbench
===========================

// Module: if_stage
// PURPOSE
//  Instruction-fetch stage upstream of control/sign_extend/ula_ctrl: owns the program counter,
//  drives a req/ready instruction-memory port and presents one fetched instruction per cycle
//  through a registered IF/ID slot. It honours downstream stall and squashes wrong-path fetches
//  on branch/jump redirect. All outputs except imem_req/imem_addr are registered.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset; bits [1:0] forced to 0
//  NOP_INSTR  32'h0000_0000  value driven on if_instr whenever if_valid=0
// PORTS
//  clock          in   1   single clock, all state on rising edge
//  reset          in   1   synchronous, active-high
//  imem_req       out  1   fetch request; held until imem_ready
//  imem_addr      out  32  word-aligned fetch address; stable while imem_req=1
//  imem_ready     in   1   imem_rdata valid this cycle; may be high in the cycle req rises
//  imem_rdata     in   32  instruction word
//  stall          in   1   downstream cannot accept; IF/ID slot must hold
//  branch_taken   in   1   redirect from branch resolution (older instruction)
//  branch_target  in   32  branch destination
//  jump           in   1   redirect from jump decode
//  jump_target    in   32  jump destination
//  if_valid       out  1   IF/ID slot holds a live instruction
//  if_instr       out  32  instruction (feeds instruction[31:0] of decode)
//  if_pc          out  32  address of if_instr
//  if_pc_plus4    out  32  if_pc + 4 (mod 2^32)
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=FETCH, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_plus4=0,
//    hold buffer empty. imem_req=0 in the reset cycle; first request is issued the cycle after.
//    Reset mid-transaction abandons the request; imem shares the same reset.
//  - States: FETCH (req=1, addr=pc), HOLD (req=0; fetched word parked in hold buffer),
//    DROP (req=1, addr=drop_addr; awaiting a squashed response).
//  - Slot free this cycle := !if_valid || !stall.
//  - FETCH & ready & no redirect: slot free -> load slot {rdata, pc, pc+4}, if_valid=1,
//    pc<=pc+4, stay FETCH (1 instruction/cycle with zero-wait memory). Slot not free ->
//    park word in hold buffer, pc<=pc+4, go HOLD.
//  - FETCH & !ready & no redirect: keep req and addr; slot drains normally (if !stall, if_valid<=0).
//  - HOLD: when slot free, move buffer into slot, go FETCH (request next cycle).
//  - Slot with stall=1 keeps all if_* values unchanged.
//  - Redirect (branch_taken | jump): target = branch_taken ? branch_target : jump_target
//    (branch wins), bits [1:0] forced to 0. Same cycle: if_valid<=0 (overrides stall),
//    hold buffer cleared, pc<=target. If FETCH with request outstanding and !ready:
//    drop_addr<=old pc, go DROP. Else (ready this cycle, or HOLD/DROP): response discarded, go
//    FETCH (DROP with !ready stays DROP, drop_addr unchanged).
//  - DROP: keep req/addr until ready; discard rdata; go FETCH at pc. Redirect in DROP only
//    updates pc.
//  - Latency: zero-wait memory -> instruction visible on if_* the cycle after req.
//  - PC arithmetic 32-bit, wraps: 32'hFFFF_FFFC + 4 = 32'h0000_0000, no flag.
//  - if_instr = NOP_INSTR whenever if_valid=0 (flushed slots decode as NOP).
// STRUCTURE
//  - Shared include mips_defs.vh: NOP_INSTR value, RESET_PC default, IF state encodings
//    (IF_FETCH=2'd0, IF_HOLD=2'd1, IF_DROP=2'd2).
//  - One sub-module if_id_reg: IF/ID slot (load, hold, flush, valid) reusable for ID/EX.
//  - PC, state machine, hold buffer and redirect mux inline in if_stage.
// TESTING
//  1. reset 2 cycles, ready tied 1, rdata=addr^32'hA5A5_0000 -> if_pc 0,4,8,C on
//     consecutive cycles, matching if_instr, if_pc_plus4 = if_pc+4.
//  2. ready delayed 3 cycles on addr 0x8 -> req high 4 cycles, addr stable at 0x8,
//     exactly one if_valid pulse carrying if_pc=0x8.
//  3. stall=1 while 0x10 returns with slot full -> HOLD, req=0, slot unchanged; stall=0 ->
//     held 0x10 delivered next cycle, fetch of 0x14 issued the cycle after.
//  4. branch_taken to 0x200 while 0x20 outstanding (ready low) -> if_valid=0 next cycle, req
//     stays at 0x20 until ready, data discarded, next valid if_pc=0x200.
//  5. branch_taken (0x103) and jump (0x400) same cycle -> next valid if_pc=0x100.
//  6. RESET_PC=32'hFFFF_FFFC, zero-wait -> if_pc FFFF_FFFC then 0000_0000, if_pc_plus4
//     of first = 0; reset asserted mid-wait -> req=0, outputs at reset values next cycle.

Source files
------------

// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared constants, state encoding and slot record for the fetch stage
package if_stage_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef enum logic [1:0] {
        IF_FETCH = 2'd0,
        IF_HOLD  = 2'd1,
        IF_DROP  = 2'd2
    } if_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_plus4;
    } if_id_t;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline slot with load, stall-hold, flush and valid; flushed slots carry NOP
module if_id_reg
    import if_stage_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   load_i,
    input  logic   flush_i,
    input  logic   stall_i,
    input  if_id_t data_i,
    output logic   valid_o,
    output if_id_t data_o
);

    logic   valid_q;
    if_id_t data_q;

    // Flush beats load; an unstalled slot with nothing new drains to NOP.
    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q          <= 1'b0;
            data_q.instr     <= NOP_INSTR;
            data_q.pc        <= '0;
            data_q.pc_plus4  <= '0;
        end else if (flush_i || (!stall_i && !load_i)) begin
            valid_q      <= 1'b0;
            data_q.instr <= NOP_INSTR;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch: PC, imem req/ready port, hold buffer, redirect squash, IF/ID slot
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    if_state_e   state_q;
    logic [31:0] pc_q;
    logic [31:0] drop_addr_q;
    logic [31:0] hold_instr_q;
    logic [31:0] hold_pc_q;

    logic        redirect;
    logic [31:0] target;
    logic        slot_free;
    logic        slot_load;
    if_id_t      slot_din;
    if_id_t      slot_q;

    assign redirect  = branch_taken | jump;
    assign target    = word_align(branch_taken ? branch_target : jump_target);
    assign slot_free = !if_valid || !stall;

    assign imem_req  = !reset && (state_q != IF_HOLD);
    assign imem_addr = (state_q == IF_DROP) ? drop_addr_q : pc_q;

    always_comb begin
        slot_load         = 1'b0;
        slot_din.instr    = imem_rdata;
        slot_din.pc       = pc_q;
        slot_din.pc_plus4 = pc_q + 32'd4;
        if (!redirect && slot_free) begin
            if (state_q == IF_FETCH && imem_ready) begin
                slot_load = 1'b1;
            end else if (state_q == IF_HOLD) begin
                slot_load         = 1'b1;
                slot_din.instr    = hold_instr_q;
                slot_din.pc       = hold_pc_q;
                slot_din.pc_plus4 = hold_pc_q + 32'd4;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IF_FETCH;
            pc_q         <= word_align(RESET_PC);
            drop_addr_q  <= '0;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
        end else if (redirect) begin
            pc_q         <= target;
            hold_instr_q <= '0;
            hold_pc_q    <= '0;
            // An unanswered request must still be consumed, so remember where it went.
            case (state_q)
                IF_FETCH: begin
                    if (!imem_ready) begin
                        drop_addr_q <= pc_q;
                        state_q     <= IF_DROP;
                    end
                end
                IF_DROP:  if (imem_ready) state_q <= IF_FETCH;
                default:  state_q <= IF_FETCH;
            endcase
        end else begin
            case (state_q)
                IF_FETCH: begin
                    if (imem_ready) begin
                        pc_q <= pc_q + 32'd4;
                        if (!slot_free) begin
                            hold_instr_q <= imem_rdata;
                            hold_pc_q    <= pc_q;
                            state_q      <= IF_HOLD;
                        end
                    end
                end
                IF_HOLD:  if (slot_free) state_q <= IF_FETCH;
                IF_DROP:  if (imem_ready) state_q <= IF_FETCH;
                default:  state_q <= IF_FETCH;
            endcase
        end
    end

    if_id_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id (
        .clock   (clock),
        .reset   (reset),
        .load_i  (slot_load),
        .flush_i (redirect),
        .stall_i (stall),
        .data_i  (slot_din),
        .valid_o (if_valid),
        .data_o  (slot_q)
    );

    assign if_instr    = slot_q.instr;
    assign if_pc       = slot_q.pc;
    assign if_pc_plus4 = slot_q.pc_plus4;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed vector table, wrap/reset sequence and randomized stream check for if_stage
module tb_if_stage;
    import if_stage_pkg::*;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset, imem_ready, stall, branch_taken, jump;
    logic [31:0] branch_target, jump_target;
    logic        imem_req, if_valid;
    logic [31:0] imem_addr, imem_rdata, if_instr, if_pc, if_pc_plus4;

    logic        reset2, ready2, req2, valid2;
    logic [31:0] addr2, rdata2, instr2, pc2, pc4_2;

    assign imem_rdata = imem_addr ^ KEY;
    assign rdata2     = addr2 ^ KEY;

    if_stage u_dut (
        .clock(clock), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
        .jump_target(jump_target), .if_valid(if_valid), .if_instr(if_instr),
        .if_pc(if_pc), .if_pc_plus4(if_pc_plus4)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
        .clock(clock), .reset(reset2), .imem_req(req2), .imem_addr(addr2),
        .imem_ready(ready2), .imem_rdata(rdata2), .stall(1'b0),
        .branch_taken(1'b0), .branch_target(32'h0), .jump(1'b0),
        .jump_target(32'h0), .if_valid(valid2), .if_instr(instr2),
        .if_pc(pc2), .if_pc_plus4(pc4_2)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rdy, stl, br, jmp;
        logic [31:0] bt, jt;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    function automatic vec_t v(input logic rdy, input logic stl, input logic br, input logic [31:0] bt,
                               input logic jmp, input logic [31:0] jt, input logic req,
                               input logic [31:0] addr, input logic vld, input logic [31:0] pc);
        vec_t r;
        r.rdy = rdy; r.stl = stl; r.br = br; r.bt = bt; r.jmp = jmp; r.jt = jt;
        r.req = req; r.addr = addr; r.vld = vld; r.pc = pc;
        return r;
    endfunction

    vec_t vecs[20];

    logic        p_req, p_rdy, p_redir, p_valid, p_stall;
    logic [31:0] p_addr, p_pc, p_instr, exp_pc;
    int          deliveries;

    initial begin
        vecs[0]  = v(1, 0, 0, 0,     0, 0,     1, 32'h000, 0, 0);
        vecs[1]  = v(1, 0, 0, 0,     0, 0,     1, 32'h004, 1, 32'h000);
        vecs[2]  = v(0, 0, 0, 0,     0, 0,     1, 32'h008, 1, 32'h004);
        vecs[3]  = v(0, 0, 0, 0,     0, 0,     1, 32'h008, 0, 0);
        vecs[4]  = v(0, 0, 0, 0,     0, 0,     1, 32'h008, 0, 0);
        vecs[5]  = v(1, 0, 0, 0,     0, 0,     1, 32'h008, 0, 0);
        vecs[6]  = v(1, 0, 0, 0,     0, 0,     1, 32'h00C, 1, 32'h008);
        vecs[7]  = v(1, 1, 0, 0,     0, 0,     1, 32'h010, 1, 32'h00C);
        vecs[8]  = v(1, 1, 0, 0,     0, 0,     0, 32'h000, 1, 32'h00C);
        vecs[9]  = v(1, 0, 0, 0,     0, 0,     0, 32'h000, 1, 32'h00C);
        vecs[10] = v(1, 0, 0, 0,     0, 0,     1, 32'h014, 1, 32'h010);
        vecs[11] = v(1, 0, 0, 0,     0, 0,     1, 32'h018, 1, 32'h014);
        vecs[12] = v(1, 0, 0, 0,     0, 0,     1, 32'h01C, 1, 32'h018);
        vecs[13] = v(0, 0, 1, 32'h200, 0, 0,   1, 32'h020, 1, 32'h01C);
        vecs[14] = v(0, 0, 0, 0,     0, 0,     1, 32'h020, 0, 0);
        vecs[15] = v(1, 0, 0, 0,     0, 0,     1, 32'h020, 0, 0);
        vecs[16] = v(1, 0, 0, 0,     0, 0,     1, 32'h200, 0, 0);
        vecs[17] = v(1, 0, 1, 32'h103, 1, 32'h400, 1, 32'h204, 1, 32'h200);
        vecs[18] = v(1, 0, 0, 0,     0, 0,     1, 32'h100, 0, 0);
        vecs[19] = v(1, 0, 0, 0,     0, 0,     1, 32'h104, 1, 32'h100);

        reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0; reset2 = 1'b1; ready2 = 1'b1;

        #2;
        check("reset_cycle_req", {31'b0, imem_req}, 32'd0);
        @(posedge clock); #1;
        check("reset_valid", {31'b0, if_valid}, 32'd0);
        check("reset_instr", if_instr, NOP);
        check("reset_pc", if_pc, 32'd0);
        check("reset_pc4", if_pc_plus4, 32'd0);
        check("reset_req", {31'b0, imem_req}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            imem_ready = vecs[i].rdy; stall = vecs[i].stl;
            branch_taken = vecs[i].br; branch_target = vecs[i].bt;
            jump = vecs[i].jmp; jump_target = vecs[i].jt;
            #2;
            check($sformatf("vec%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].req});
            if (vecs[i].req) check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].addr);
            check($sformatf("vec%0d_valid", i), {31'b0, if_valid}, {31'b0, vecs[i].vld});
            if (vecs[i].vld) begin
                check($sformatf("vec%0d_pc", i), if_pc, vecs[i].pc);
                check($sformatf("vec%0d_pc4", i), if_pc_plus4, vecs[i].pc + 32'd4);
                check($sformatf("vec%0d_instr", i), if_instr, vecs[i].pc ^ KEY);
            end else begin
                check($sformatf("vec%0d_nop", i), if_instr, NOP);
            end
            @(posedge clock); #1;
        end
        branch_taken = 1'b0; jump = 1'b0; stall = 1'b0;

        // PC wrap at the top of the address space, then reset during an outstanding fetch.
        reset2 = 1'b0; ready2 = 1'b1;
        #2;
        check("wrap_req", {31'b0, req2}, 32'd1);
        check("wrap_addr0", addr2, 32'hFFFF_FFFC);
        check("wrap_valid0", {31'b0, valid2}, 32'd0);
        @(posedge clock); #1;
        check("wrap_valid1", {31'b0, valid2}, 32'd1);
        check("wrap_pc1", pc2, 32'hFFFF_FFFC);
        check("wrap_pc4_1", pc4_2, 32'h0000_0000);
        check("wrap_instr1", instr2, 32'hFFFF_FFFC ^ KEY);
        check("wrap_addr1", addr2, 32'h0000_0000);
        @(posedge clock); #1;
        check("wrap_pc2", pc2, 32'h0000_0000);
        check("wrap_pc4_2", pc4_2, 32'h0000_0004);
        ready2 = 1'b0;
        #2;
        check("wrap_addr2", addr2, 32'h0000_0004);
        @(posedge clock); #1;
        check("wait_req", {31'b0, req2}, 32'd1);
        check("wait_valid", {31'b0, valid2}, 32'd0);
        reset2 = 1'b1;
        #2;
        check("midreset_req", {31'b0, req2}, 32'd0);
        @(posedge clock); #1;
        check("midreset_valid", {31'b0, valid2}, 32'd0);
        check("midreset_instr", instr2, NOP);
        check("midreset_pc", pc2, 32'd0);
        check("midreset_pc4", pc4_2, 32'd0);
        reset2 = 1'b0;
        #2;
        check("postreset_req", {31'b0, req2}, 32'd1);
        check("postreset_addr", addr2, 32'hFFFF_FFFC);

        // Randomized run: delivered PCs must form the program-order stream implied by redirects.
        reset = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        reset = 1'b0;
        exp_pc = 32'd0; deliveries = 0;
        p_req = 1'b0; p_rdy = 1'b0; p_redir = 1'b0; p_valid = 1'b0; p_stall = 1'b0;
        p_addr = '0; p_pc = '0; p_instr = '0;
        for (int c = 0; c < 3000; c++) begin
            imem_ready    = ($urandom_range(0, 2) != 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 15) == 0);
            jump          = ($urandom_range(0, 15) == 0);
            branch_target = $urandom;
            jump_target   = $urandom;
            #2;
            if (p_req && !p_rdy) begin
                check("rnd_req_held", {31'b0, imem_req}, 32'd1);
                check("rnd_addr_stable", imem_addr, p_addr);
            end
            if (imem_req) check("rnd_addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
            if (p_redir) begin
                check("rnd_flush", {31'b0, if_valid}, 32'd0);
            end else if (p_valid && p_stall) begin
                check("rnd_stall_valid", {31'b0, if_valid}, 32'd1);
                check("rnd_stall_pc", if_pc, p_pc);
                check("rnd_stall_instr", if_instr, p_instr);
            end else if (if_valid) begin
                check("rnd_pc", if_pc, exp_pc);
                check("rnd_instr", if_instr, exp_pc ^ KEY);
                check("rnd_pc4", if_pc_plus4, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
                deliveries++;
            end
            if (!if_valid) check("rnd_nop", if_instr, NOP);
            if (branch_taken || jump)
                exp_pc = (branch_taken ? branch_target : jump_target) & 32'hFFFF_FFFC;
            p_req = imem_req; p_rdy = imem_ready; p_addr = imem_addr;
            p_redir = branch_taken | jump; p_valid = if_valid; p_stall = stall;
            p_pc = if_pc; p_instr = if_instr;
            @(posedge clock); #1;
        end
        check("rnd_progress", {31'b0, (deliveries > 200)}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
